// File: rtl/soc_pio_pkg.sv
// soc_pio_pkg: shared register map, edge-mode encodings and helpers for the input PIO
package soc_pio_pkg;
  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE    = 2'd3;
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/pio_sync_debounce.sv
// pio_sync_debounce: one input bit through a synchroniser chain and optional hold-time debounce
module pio_sync_debounce
  import soc_pio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic sync;
  assign sync_d = {sync_q[SYNC_STAGES-2:0], din};
  assign sync = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_q <= '0;
    else sync_q <= sync_d;
  if (DEBOUNCE_CYCLES == 0) begin : g_byp
    assign dout = sync;
  end else begin : g_db
    localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic stable_q, stable_d;
    logic hit;
    // a new value is accepted only after it has differed from stable for the full window
    always_comb begin
      hit = (sync != stable_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
      cnt_d = (sync == stable_q || hit) ? '0 : cnt_q + 1'b1;
      stable_d = hit ? sync : stable_q;
    end
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        cnt_q <= '0;
        stable_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        stable_q <= stable_d;
      end
    assign dout = stable_q;
  end
endmodule

// File: rtl/pio_in_edge_irq.sv
// pio_in_edge_irq: Avalon-MM input PIO with sticky edge capture, W1C clear and masked level IRQ
module pio_in_edge_irq
  import soc_pio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  logic [WIDTH-1:0] stable, det, wd;
  logic [WIDTH-1:0] prev_q, mask_q, mask_d, edge_q, edge_d;
  logic [31:0] readdata_q, readdata_d;
  logic irq_q, irq_d, wr, unused_wd;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sd (
      .clk(clk), .reset_n(reset_n), .din(in_port[i]), .dout(stable[i])
    );
  end
  assign unused_wd = ^(writedata >> WIDTH);
  // a set from a same-cycle edge overrides the write-1-to-clear
  always_comb begin
    wr = chipselect && !write_n;
    wd = writedata[WIDTH-1:0];
    det = (EDGE_TYPE == EDGE_RISING)  ? (stable & ~prev_q) :
          (EDGE_TYPE == EDGE_FALLING) ? (~stable & prev_q) : (stable ^ prev_q);
    mask_d = (wr && address == PIO_ADDR_IRQMASK) ? wd : mask_q;
    edge_d = (edge_q & ~((wr && address == PIO_ADDR_EDGE) ? wd : '0)) | det;
    readdata_d = (address == PIO_ADDR_DATA)    ? 32'(stable) :
                 (address == PIO_ADDR_IRQMASK) ? 32'(mask_q) :
                 (address == PIO_ADDR_EDGE)    ? 32'(edge_q) : 32'd0;
    irq_d = |(edge_q & mask_q);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      prev_q <= '0;
      mask_q <= '0;
      edge_q <= '0;
      readdata_q <= '0;
      irq_q <= 1'b0;
    end else begin
      prev_q <= stable;
      mask_q <= mask_d;
      edge_q <= edge_d;
      readdata_q <= readdata_d;
      irq_q <= irq_d;
    end
  assign readdata = readdata_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_pio_in_edge_irq.sv
// tb_pio_in_edge_irq: directed checks of four PIO configurations sharing one Avalon bus
module tb_pio_in_edge_irq;
  logic clk = 0, reset_n = 0, chipselect = 0, write_n = 1;
  logic [1:0] address = 0;
  logic [31:0] writedata = 0;
  logic [7:0] in0 = 0, in1 = 0, in2 = 0, in3 = 0;
  logic [31:0] rd0, rd1, rd2, rd3;
  logic irq0, irq1, irq2, irq3;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd0), .in_port(in0), .irq(irq0));
  pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd1), .in_port(in1), .irq(irq1));
  pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd2), .in_port(in2), .irq(irq2));
  pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) u3 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd3), .in_port(in3), .irq(irq3));

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1;
    write_n = 0;
    tick();
    chipselect = 0;
    write_n = 1;
  endtask

  task automatic test_reset;
    in0 = 8'hA5;
    tick(2);
    n_chk++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL reset_rd got %h want %h", rd0, 32'h0); end
    n_chk++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq0); end
    reset_n = 1;
    address = 0;
    tick(2);
    n_chk++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL data_early got %h want %h", rd0, 32'h0); end
    tick();
    n_chk++; if (rd0 !== 32'hA5) begin n_fail++; $display("FAIL data_a5 got %h want %h", rd0, 32'hA5); end
    address = 1; tick();
    n_chk++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL addr1 got %h want %h", rd0, 32'h0); end
    address = 2; tick();
    n_chk++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL mask_rst got %h want %h", rd0, 32'h0); end
    address = 3; tick();
    n_chk++; if (rd0 !== 32'hA5) begin n_fail++; $display("FAIL edge_init got %h want %h", rd0, 32'hA5); end
  endtask

  task automatic test_rise_irq;
    in0 = 8'hA4;
    tick(4);
    wr(2, 32'h01);
    wr(3, 32'hFF);
    tick(2);
    address = 3;
    in0 = 8'hA5;
    tick(3);
    n_chk++; if (rd0 !== 32'h0 || irq0 !== 1'b0) begin n_fail++; $display("FAIL rise_early got %h/%b want 0/0", rd0, irq0); end
    tick();
    n_chk++; if (rd0 !== 32'h01) begin n_fail++; $display("FAIL rise_edge got %h want %h", rd0, 32'h01); end
    n_chk++; if (irq0 !== 1'b1) begin n_fail++; $display("FAIL rise_irq got %b want 1", irq0); end
    wr(3, 32'h01);
    tick();
    n_chk++; if (rd0 !== 32'h0 || irq0 !== 1'b0) begin n_fail++; $display("FAIL w1c got %h/%b want 0/0", rd0, irq0); end
  endtask

  task automatic test_mask;
    wr(2, 32'h0);
    address = 3;
    in0 = 8'hAD;
    tick(5);
    n_chk++; if (rd0 !== 32'h08) begin n_fail++; $display("FAIL mask_edge got %h want %h", rd0, 32'h08); end
    n_chk++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL masked_irq got %b want 0", irq0); end
    wr(2, 32'h08);
    n_chk++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL unmask_early got %b want 0", irq0); end
    tick();
    n_chk++; if (irq0 !== 1'b1) begin n_fail++; $display("FAIL unmask_irq got %b want 1", irq0); end
    wr(3, 32'hFF);
    wr(2, 32'h0);
  endtask

  task automatic test_debounce;
    address = 0;
    in1 = 8'h04;
    tick(3);
    in1 = 8'h00;
    tick(10);
    n_chk++; if (rd1 !== 32'h0) begin n_fail++; $display("FAIL glitch_data got %h want %h", rd1, 32'h0); end
    address = 3; tick();
    n_chk++; if (rd1 !== 32'h0) begin n_fail++; $display("FAIL glitch_edge got %h want %h", rd1, 32'h0); end
    address = 0; tick();
    in1 = 8'h04;
    tick(6);
    n_chk++; if (rd1 !== 32'h0) begin n_fail++; $display("FAIL db_early got %h want %h", rd1, 32'h0); end
    in1 = 8'h00;
    tick();
    n_chk++; if (rd1 !== 32'h04) begin n_fail++; $display("FAIL db_data got %h want %h", rd1, 32'h04); end
    address = 3;
    tick(12);
    n_chk++; if (rd1 !== 32'h04) begin n_fail++; $display("FAIL db_edge got %h want %h", rd1, 32'h04); end
    wr(3, 32'hFF);
  endtask

  task automatic test_back_to_back;
    in0 = 8'h8D;
    tick(5);
    in0 = 8'hAD;
    tick(2);
    wr(3, 32'h20);
    tick();
    n_chk++; if (rd0 !== 32'h20) begin n_fail++; $display("FAIL set_wins got %h want %h", rd0, 32'h20); end
    wr(3, 32'h20);
    tick();
    n_chk++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL clr_after got %h want %h", rd0, 32'h0); end
  endtask

  task automatic test_edge_modes;
    wr(3, 32'hFF);
    in0 = 8'hAC;
    in2 = 8'h01;
    in3 = 8'h01;
    tick(5);
    n_chk++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL rise_mode_fall got %h want %h", rd0, 32'h0); end
    n_chk++; if (rd2 !== 32'h0) begin n_fail++; $display("FAIL fall_mode_rise got %h want %h", rd2, 32'h0); end
    n_chk++; if (rd3 !== 32'h01) begin n_fail++; $display("FAIL any_mode_rise got %h want %h", rd3, 32'h01); end
    wr(3, 32'hFF);
    in2 = 8'h00;
    in3 = 8'h00;
    tick(5);
    n_chk++; if (rd2 !== 32'h01) begin n_fail++; $display("FAIL fall_mode_fall got %h want %h", rd2, 32'h01); end
    n_chk++; if (rd3 !== 32'h01) begin n_fail++; $display("FAIL any_mode_fall got %h want %h", rd3, 32'h01); end
    wr(2, 32'hFF);
    address = 3;
    tick(2);
    n_chk++; if (irq2 !== 1'b1 || irq3 !== 1'b1) begin n_fail++; $display("FAIL pre_rst_irq got %b%b want 11", irq2, irq3); end
    reset_n = 0;
    #1;
    n_chk++; if (rd2 !== 32'h0 || rd3 !== 32'h0) begin n_fail++; $display("FAIL mid_rst_rd got %h %h want 0 0", rd2, rd3); end
    n_chk++; if (irq2 !== 1'b0 || irq3 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_irq got %b%b want 00", irq2, irq3); end
    tick();
    reset_n = 1;
    tick(4);
    n_chk++; if (rd3 !== 32'h0) begin n_fail++; $display("FAIL post_rst_edge got %h want %h", rd3, 32'h0); end
    address = 2; tick();
    n_chk++; if (rd3 !== 32'h0) begin n_fail++; $display("FAIL post_rst_mask got %h want %h", rd3, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_rise_irq();
    test_mask();
    test_debounce();
    test_back_to_back();
    test_edge_modes();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
